// File: rtl/float_to_fixed_conv_if.sv
// float_to_fixed_conv_if
//   Handshake bundle for the float-to-fixed converter.
//   Input side : IN_VALID / IN_READY / FLOAT_IN (IEEE-754 single)
//   Output side: OUT_VALID / OUT_READY / FIXED_OUT (W-bit signed) / OVF
//   master: the surrounding logic (producer + consumer)
//   slave : the converter itself
interface float_to_fixed_conv_if #(
    parameter int W = 32
);
    logic         IN_VALID;
    logic         IN_READY;
    logic [31:0]  FLOAT_IN;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] FIXED_OUT;
    logic         OVF;

    modport master (
        output IN_VALID, FLOAT_IN, OUT_READY,
        input  IN_READY, OUT_VALID, FIXED_OUT, OVF
    );

    modport slave (
        input  IN_VALID, FLOAT_IN, OUT_READY,
        output IN_READY, OUT_VALID, FIXED_OUT, OVF
    );
endinterface

// File: rtl/float_to_fixed_conv.sv
// float_to_fixed_conv
//   Converts an IEEE-754 single into a signed W-bit fixed-point word with
//   FRAC fractional bits (result = value * 2^FRAC). One conversion in flight;
//   FSM S_IDLE -> S_UNPACK -> S_SHIFT -> S_OUT -> S_IDLE.
//   Zero/subnormal give 0; Inf/NaN/out-of-range saturate with OVF=1.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous reset, active high, overrides all handshakes
//   bus  - float_to_fixed_conv_if.slave (input and output handshakes)
// Build option:
//   F2X_ROUND_NEAREST_EN - round to nearest/even using guard+sticky;
//                          undefined: truncate magnitude toward zero.
module float_to_fixed_conv #(
    parameter int W    = 32,
    parameter int FRAC = 24
) (
    input logic                  CLK,
    input logic                  RST,
    float_to_fixed_conv_if.slave bus
);
    // Extra headroom: a left shift never exceeds W-1, so M<<sh fits in
    // W+24 bits; one more bit catches a rounding carry.
    localparam int WX = W + 25;
    localparam logic signed [9:0] SH_BIAS = 10'(FRAC - 150);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_SHIFT, S_OUT} state_t;
    state_t state, state_nxt;

    logic [31:0]       flt;
    logic              s;
    logic [23:0]       m;
    logic signed [9:0] sh;
    logic              is_zero, is_spec, is_nan;
    logic [W-1:0]      fixed;
    logic              ovf;

    logic [WX-1:0]     mag;
    logic              big;
    logic [9:0]        nsh;
    logic              pos_ovf, neg_ovf;
    logic [W-1:0]      res;
    logic              res_ovf;
`ifdef F2X_ROUND_NEAREST_EN
    logic [48:0]       ext;
    logic              guard, sticky;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.IN_READY  = 1'b0;
        bus.OUT_VALID = 1'b0;
        case (state)
            S_IDLE: begin
                bus.IN_READY = 1'b1;
                if (bus.IN_VALID) state_nxt = S_UNPACK;
            end
            S_UNPACK: state_nxt = S_SHIFT;
            S_SHIFT:  state_nxt = S_OUT;
            S_OUT: begin
                bus.OUT_VALID = 1'b1;
                if (bus.OUT_READY) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            flt     <= '0;
            s       <= 1'b0;
            m       <= '0;
            sh      <= '0;
            is_zero <= 1'b0;
            is_spec <= 1'b0;
            is_nan  <= 1'b0;
            fixed   <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.IN_VALID) flt <= bus.FLOAT_IN;
                S_UNPACK: begin
                    s       <= flt[31];
                    m       <= {1'b1, flt[22:0]};
                    sh      <= $signed({2'b00, flt[30:23]}) + SH_BIAS;
                    is_zero <= (flt[30:23] == 8'h00);
                    is_spec <= (flt[30:23] == 8'hFF);
                    is_nan  <= (flt[30:23] == 8'hFF) && (|flt[22:0]);
                end
                S_SHIFT: begin
                    fixed <= res;
                    ovf   <= res_ovf;
                end
                default: ;
            endcase
        end
    end

    // ---------------- shifter (evaluated during S_SHIFT) ----------------
    always_comb begin
        mag = '0;
        big = 1'b0;
        nsh = 10'(-sh);
`ifdef F2X_ROUND_NEAREST_EN
        ext    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
`endif
        if (!sh[9]) begin
            // Hidden bit lands at or above bit W+23: far beyond any range.
            if ($unsigned(sh) >= 10'(W)) big = 1'b1;
            else                         mag = WX'(m) << sh[6:0];
        end else begin
`ifdef F2X_ROUND_NEAREST_EN
            if (nsh > 10'd25) begin
                sticky = |m;
            end else begin
                ext    = {m, 25'b0} >> nsh;
                mag    = WX'(ext[48:25]);
                guard  = ext[24];
                sticky = |ext[23:0];
            end
`else
            mag = WX'(m >> nsh);
`endif
        end
`ifdef F2X_ROUND_NEAREST_EN
        mag = mag + WX'(guard & (sticky | mag[0]));
`endif
    end

    // ---------------- range check and sign ----------------
    always_comb begin
        pos_ovf = |mag[WX-1:W-1];
        // Negative side may reach exactly 2^(W-1).
        neg_ovf = (|mag[WX-1:W]) | (mag[W-1] & (|mag[W-2:0]));
        res     = '0;
        res_ovf = 1'b0;
        if (is_zero) begin
            res = '0;
        end else if (is_spec) begin
            res     = (is_nan || !s) ? MAX_POS : MIN_NEG;
            res_ovf = 1'b1;
        end else if (big || (s ? neg_ovf : pos_ovf)) begin
            res     = s ? MIN_NEG : MAX_POS;
            res_ovf = 1'b1;
        end else begin
            res = s ? (~mag[W-1:0] + 1'b1) : mag[W-1:0];
        end
    end

    assign bus.FIXED_OUT = fixed;
    assign bus.OVF       = ovf;
endmodule
